// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the queued fetch entry type for the fetch stage
package fetch_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN_DEFAULT-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] instr;
        logic [XLEN_DEFAULT-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO of fetched {instr, pc} pairs with flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;

    assign do_pop = pop && !empty;
    assign empty  = count == '0;
    assign full   = count == CW'(DEPTH);
    assign dout   = mem[rd_ptr];

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at DEPTH (power of two); flush empties in one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order imem requests under a credit limit and queues responses for decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEFAULT,
    parameter int               DEPTH    = 2,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall_d,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;
    logic            accept;
    logic            push;
    logic            pop;
    fetch_entry_t    head;

    // Credits cover both in-flight requests and queued entries, so every response has a slot
    assign imem_req_valid = !reset && !redirect_valid && (outstanding + q_count) < CW'(DEPTH);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
    assign pop            = instr_valid && !stall_d && !redirect_valid;
    assign instr_valid    = !q_empty;
    assign instr          = q_empty ? INSTR_NOP : head.instr;
    assign instr_pc       = head.pc;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ('{instr: imem_rsp_data, pc: rsp_pc}),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // PC, response PC and credit/drop bookkeeping; a redirect marks every still-pending response stale
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc       <= redirect_pc;
                rsp_pc   <= redirect_pc;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (accept) pc <= pc + XLEN'(4);
                if (push) rsp_pc <= rsp_pc + XLEN'(4);
                if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && q_full));
    a_rsp_expected: assert property (@(posedge clk) disable iff (reset) !(imem_rsp_valid && outstanding == '0));
endmodule
